// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: access-size encoding, store-buffer entry layout and byte-lane helpers
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W = 4;
  localparam int IDX_W = 30;
  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
    logic [BE_W-1:0]   be;
  } sb_entry_t;
  function automatic logic [BE_W-1:0] gen_be(input mem_size_e size, input logic [1:0] lo);
    return (size == SZ_W) ? 4'hF : (size == SZ_H || size == SZ_HU) ? 4'h3 << lo : 4'h1 << lo;
  endfunction
  function automatic logic [WORD_W-1:0] align_store(input logic [WORD_W-1:0] data, input logic [1:0] lo);
    return data << {lo, 3'b000};
  endfunction
  function automatic logic [WORD_W-1:0] extend_load(input logic [WORD_W-1:0] word, input mem_size_e size,
                                                    input logic [1:0] lo);
    logic [WORD_W-1:0] s;
    s = word >> {lo, 3'b000};
    return (size == SZ_B)  ? {{24{s[7]}}, s[7:0]} :
           (size == SZ_BU) ? {24'b0, s[7:0]} :
           (size == SZ_H)  ? {{16{s[15]}}, s[15:0]} :
           (size == SZ_HU) ? {16'b0, s[15:0]} : s;
  endfunction
endpackage

// File: rtl/mem_access_unit_store_buffer.sv
// store_buffer: circular store FIFO with word-index match; STORE_FWD_EN adds youngest-match forwarding
module store_buffer
  import mem_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  sb_entry_t           push_entry,
  input  logic [IDX_W-1:0]    lookup_idx,
  output logic                full,
  output logic                empty,
  output sb_entry_t           head,
  output logic [SB_DEPTH-1:0] match,
  output logic [WORD_W-1:0]   fwd_data,
  output logic [BE_W-1:0]     fwd_cover
);
  localparam int PW = $clog2(SB_DEPTH);
  sb_entry_t         r_mem [SB_DEPTH];
  logic [SB_DEPTH-1:0] r_valid;
  logic [PW-1:0]     r_head, r_tail;
  logic [PW:0]       r_count;
  assign full  = r_count[PW];
  assign empty = r_count == '0;
  assign head  = r_mem[r_head];
  // entry payload storage, written at the tail on push
  always_ff @(posedge clk)
    if (push) r_mem[r_tail] <= push_entry;
  // pointers, occupancy and per-entry valid bits
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      r_count <= r_count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  // valid entries whose word index equals the lookup index
  always_comb begin
    match = '0;
    for (int i = 0; i < SB_DEPTH; i++) match[i] = r_valid[i] && (r_mem[i].idx == lookup_idx);
  end
`ifdef STORE_FWD_EN
  logic [PW-1:0] w_p;
  // walk oldest to youngest so the last hit is the youngest matching store
  always_comb begin
    fwd_data  = '0;
    fwd_cover = '0;
    w_p       = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_p = r_head + PW'(k);
      if (match[w_p]) begin
        fwd_data  = r_mem[w_p].data;
        fwd_cover = r_mem[w_p].be;
      end
    end
  end
`else
  assign fwd_data  = '0;
  assign fwd_cover = '0;
`endif
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with store buffer, sync data RAM and LED MMIO; STORE_FWD_EN enables load forwarding
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 1024,
  parameter int               SB_DEPTH = 4,
  parameter logic [XLEN-1:0]  LED_ADDR = 32'hFFFF_0000,
  parameter int               LED_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  address,
  input  logic [XLEN-1:0]  d_in,
  input  logic [XLEN-1:0]  write_data_wb,
  input  logic             data_sel_mem,
  output logic [XLEN-1:0]  pc_add4,
  output logic [XLEN-1:0]  d_out,
  output logic             d_out_valid,
  output logic             stall,
  output logic             misaligned,
  output logic [LED_W-1:0] led,
  output logic             sb_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0]     r_ram [DEPTH];
  logic [XLEN-1:0]     r_d_out;
  logic                r_d_valid;
  logic [LED_W-1:0]    r_led;
  mem_size_e           w_size;
  logic                w_mem_op, w_mis, w_led_hit, w_fwd_ok, w_hazard, w_accept, w_push, w_pop, w_ld;
  logic                w_full, w_empty;
  logic [IDX_W-1:0]    w_idx;
  logic [BE_W-1:0]     w_be, w_fwd_cover;
  logic [XLEN-1:0]     w_wdata, w_mask, w_fwd_data, w_ld_word;
  logic [SB_DEPTH-1:0] w_match;
  sb_entry_t           w_head;
  logic                w_unused;
  assign w_size    = mem_size_e'(funct3);
  assign w_mem_op  = valid_in & (mem_read | mem_write);
  assign w_mis     = ((w_size == SZ_H || w_size == SZ_HU) & address[0]) | ((w_size == SZ_W) & |address[1:0]);
  assign w_led_hit = address[XLEN-1:2] == LED_ADDR[XLEN-1:2];
  assign w_idx     = IDX_W'(address[AW+1:2]);
  assign w_be      = gen_be(w_size, address[1:0]);
  assign w_wdata   = align_store(data_sel_mem ? write_data_wb : d_in, address[1:0]);
  assign w_mask    = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
`ifdef STORE_FWD_EN
  assign w_fwd_ok  = (w_fwd_cover & w_be) == w_be;
`else
  assign w_fwd_ok  = 1'b0;
`endif
  assign w_hazard  = mem_write ? w_full : (|w_match & ~w_fwd_ok);
  assign stall     = w_mem_op & ~w_mis & ~w_led_hit & w_hazard;
  assign misaligned = w_mem_op & w_mis;
  assign w_accept  = w_mem_op & ~w_mis & ~stall;
  assign w_push    = w_accept & mem_write & ~w_led_hit;
  assign w_pop     = ~w_accept & ~w_empty;
  assign w_ld      = w_accept & mem_read;
  assign w_ld_word = w_led_hit ? XLEN'(r_led) : w_fwd_ok ? w_fwd_data : r_ram[address[AW+1:2]];
  assign w_unused  = ^{w_mask, w_head.idx};
  assign pc_add4   = pc_in + XLEN'(4);
  assign d_out     = r_d_out;
  assign d_out_valid = r_d_valid;
  assign led       = r_led;
  assign sb_empty  = w_empty;
  store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_entry('{idx: w_idx, data: w_wdata, be: w_be}),
    .lookup_idx(w_idx),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head),
    .match     (w_match),
    .fwd_data  (w_fwd_data),
    .fwd_cover (w_fwd_cover)
  );
  // drain the buffer head into RAM under its byte enables
  always_ff @(posedge clk)
    if (w_pop)
      for (int b = 0; b < BE_W; b++)
        if (w_head.be[b]) r_ram[w_head.idx[AW-1:0]][8*b +: 8] <= w_head.data[8*b +: 8];
  // load result, its valid pulse and the LED register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_d_out   <= '0;
      r_d_valid <= 1'b0;
      r_led     <= '0;
    end else begin
      r_d_valid <= w_ld;
      if (w_ld) r_d_out <= extend_load(w_ld_word, w_size, address[1:0]);
      if (w_accept & mem_write & w_led_hit)
        r_led <= (r_led & ~w_mask[LED_W-1:0]) | (w_wdata[LED_W-1:0] & w_mask[LED_W-1:0]);
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench against a byte-addressed program-order memory model
module tb_mem_access_unit;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_0000;
  logic        clk = 1'b0;
  logic        reset, valid_in, mem_read, mem_write, data_sel_mem;
  logic [2:0]  funct3;
  logic [31:0] pc_in, address, d_in, write_data_wb, pc_add4, d_out;
  logic        d_out_valid, stall, misaligned, sb_empty;
  logic [15:0] led;
  int          vectors = 0;
  int          errors = 0;
  logic [7:0]  mdl [0:63];
  logic [15:0] mdl_led = 16'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .pc_in(pc_in), .address(address), .d_in(d_in), .write_data_wb(write_data_wb),
    .data_sel_mem(data_sel_mem), .pc_add4(pc_add4), .d_out(d_out), .d_out_valid(d_out_valid),
    .stall(stall), .misaligned(misaligned), .led(led), .sb_empty(sb_empty)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int size_of(input logic [2:0] f);
    return (f[1:0] == 2'd2) ? 4 : (f[1:0] == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f);
    int n = size_of(f);
    logic [31:0] v = 32'h0;
    if (a == LED_ADDR) return {16'h0, mdl_led};
    for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(a[5:0]) + i]) << (8 * i));
    if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] dat);
    int n = size_of(f);
    for (int i = 0; i < n; i++) begin
      if (a[31:2] == LED_ADDR[31:2]) begin
        if (int'(a[1:0]) + i < 2) mdl_led[8*(int'(a[1:0])+i) +: 8] = dat[8*i +: 8];
      end else mdl[int'(a[5:0]) + i] = dat[8*i +: 8];
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op(input logic rd, input logic [2:0] f, input logic [31:0] a, input logic [31:0] dat,
                    output int stalls);
    logic sel = 1'($urandom_range(0, 1));
    logic [31:0] exp = mdl_load(a, f);
    logic [31:0] pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
    valid_in = 1'b1; mem_read = rd; mem_write = ~rd; funct3 = f; address = a;
    data_sel_mem = sel; pc_in = pc;
    write_data_wb = sel ? dat : $urandom;
    d_in = sel ? $urandom : dat;
    stalls = 0;
    @(negedge clk);
    vectors++;
    if (pc_add4 !== pc + 32'd4) begin
      errors++; $display("FAIL pc_add4 got=%h want=%h", pc_add4, pc + 32'd4);
    end
    while (stall && stalls < 64) begin
      stalls++;
      @(negedge clk);
    end
    if (stall) begin
      vectors++; errors++; $display("FAIL op_stall_timeout addr=%h got stall=1 want 0", a);
    end
    @(posedge clk); #1;
    if (!rd) mdl_store(a, f, dat);
    else begin
      vectors++;
      if (d_out_valid !== 1'b1 || d_out !== exp) begin
        errors++;
        $display("FAIL load f=%0d addr=%h got valid=%b data=%h want valid=1 data=%h", f, a, d_out_valid, d_out, exp);
      end
    end
  endtask

  task automatic wait_empty();
    int cnt = 0;
    idle(1);
    while (!sb_empty && cnt < 64) begin
      cnt++;
      @(posedge clk); #1;
    end
    vectors++;
    if (sb_empty !== 1'b1) begin
      errors++; $display("FAIL drain got sb_empty=%b want 1", sb_empty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b010;
    pc_in = 32'h0; address = 32'h0; d_in = 32'h0; write_data_wb = 32'h0; data_sel_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (sb_empty !== 1'b1 || led !== 16'h0 || d_out_valid !== 1'b0 || d_out !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got empty=%b led=%h dv=%b d=%h stall=%b want 1/0/0/0/0",
               sb_empty, led, d_out_valid, d_out, stall);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_init();
    int s;
    for (int w = 0; w < 16; w++) op(1'b0, 3'b010, 32'(4 * w), $urandom, s);
    wait_empty();
  endtask

  task automatic test_led();
    int s;
    op(1'b0, 3'b001, LED_ADDR, 32'hABCD_1234, s);
    vectors++;
    if (led !== 16'h1234 || sb_empty !== 1'b1) begin
      errors++; $display("FAIL led_store got led=%h empty=%b want 1234/1", led, sb_empty);
    end
    op(1'b1, 3'b010, LED_ADDR, 32'h0, s);
    idle(1);
  endtask

  task automatic test_misaligned();
    int s;
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; address = 32'h2;
    @(negedge clk);
    vectors++;
    if (misaligned !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL misaligned_lw got mis=%b stall=%b want 1/0", misaligned, stall);
    end
    @(posedge clk); #1;
    vectors++;
    if (d_out_valid !== 1'b0) begin
      errors++; $display("FAIL misaligned_lw_valid got %b want 0", d_out_valid);
    end
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b001; address = 32'h1;
    d_in = 32'h5555_5555; write_data_wb = 32'h5555_5555;
    @(negedge clk);
    vectors++;
    if (misaligned !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL misaligned_sh got mis=%b stall=%b want 1/0", misaligned, stall);
    end
    @(posedge clk); #1;
    vectors++;
    if (sb_empty !== 1'b1) begin
      errors++; $display("FAIL misaligned_sh_buffer got empty=%b want 1", sb_empty);
    end
    idle(2);
    op(1'b1, 3'b010, 32'h0, 32'h0, s);
    idle(1);
  endtask

  task automatic test_sw_lw();
    int s;
    op(1'b0, 3'b010, 32'h10, 32'hDEAD_BEEF, s);
    idle(2);
    op(1'b1, 3'b010, 32'h10, 32'h0, s);
    idle(1);
    vectors++;
    if (d_out_valid !== 1'b0 || d_out !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_pulse got dv=%b d=%h want 0/deadbeef", d_out_valid, d_out);
    end
  endtask

  task automatic test_sb_lb();
    int s, want;
`ifdef STORE_FWD_EN
    want = 0;
`else
    want = 1;
`endif
    op(1'b0, 3'b000, 32'h13, 32'h1234_5680, s);
    op(1'b1, 3'b000, 32'h13, 32'h0, s);
    vectors++;
    if (s != want) begin
      errors++; $display("FAIL lb_stall_cycles got %0d want %0d", s, want);
    end
    op(1'b1, 3'b100, 32'h13, 32'h0, s);
    vectors++;
    if (d_out !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_value got %h want 00000080", d_out);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int s;
    wait_empty();
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 3'b010, 32'h20 + 32'(4 * i), $urandom, s);
      vectors++;
      if (s != ((i == 4) ? 1 : 0)) begin
        errors++; $display("FAIL b2b_stall store=%0d got %0d want %0d", i, s, (i == 4) ? 1 : 0);
      end
    end
    for (int i = 0; i < 5; i++) op(1'b1, 3'b010, 32'h20 + 32'(4 * i), 32'h0, s);
    idle(1);
  endtask

  task automatic test_reset_mid();
    int s;
    logic [7:0] snap [0:63];
    wait_empty();
    snap = mdl;
    for (int i = 0; i < 3; i++) op(1'b0, 3'b010, 32'h34 + 32'(4 * i), $urandom, s);
    vectors++;
    if (sb_empty !== 1'b0) begin
      errors++; $display("FAIL pre_reset_queue got empty=%b want 0", sb_empty);
    end
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (sb_empty !== 1'b1 || led !== 16'h0 || d_out_valid !== 1'b0 || d_out !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got empty=%b led=%h dv=%b d=%h want 1/0/0/0", sb_empty, led, d_out_valid, d_out);
    end
    mdl = snap;
    mdl_led = 16'h0;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) op(1'b1, 3'b010, 32'h34 + 32'(4 * i), 32'h0, s);
    idle(1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic rd;
      logic [2:0] f;
      int k, s;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      k = int'($urandom_range(0, rd ? 4 : 2));
      f = (k == 3) ? 3'd4 : (k == 4) ? 3'd5 : 3'(k);
      a = 32'($urandom_range(0, 63)) & ~32'(size_of(f) - 1);
      op(rd, f, a, $urandom, s);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_init();
    test_led();
    test_misaligned();
    test_sw_lw();
    test_sb_lb();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
